// File: rtl/embedded_system_mem_tester.sv
// embedded_system_mem_tester
//   Write/read-back tester for a single-port on-chip memory behind an
//   Avalon-MM master. Each word in [base_addr, base_addr+length) is written
//   with pattern(a) = seed + a. The block then reads the words back and checks
//   each one against that pattern.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   start               one-cycle request, accepted only in IDLE
//   base_addr, length   range under test, sampled with start
//   seed                pattern seed, sampled with start
//   busy                test in progress (cycle after start up to done)
//   done                one-cycle completion pulse
//   pass                result, valid from done until the next accepted start
//   range_err           requested range runs past DEPTH
//   err_count           saturating count of mismatching words
//   first_err_addr      address of the first mismatching word
//   avm_*               Avalon-MM master; readdata arrives 1 cycle after address

module embedded_system_mem_tester #(
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 25000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              range_err,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_clken,
    input  logic [31:0]       avm_readdata
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FIN} state_t;

    // End of range is formed one bit wider than length so that a large
    // base+length cannot wrap around and look legal.
    localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE     = (ADDR_W+1)'(1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q;      // address of the access on the bus now
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   rem_q;       // accesses left in the current phase
    logic [31:0]       seed_q;

    // Read issued last cycle, compared against avm_readdata this cycle
    logic              cmp_vld;
    logic [ADDR_W-1:0] cmp_addr;
    logic [31:0]       cmp_exp;

    logic              accept, bad_range, issue, issue_wr, mismatch;
    logic [ADDR_W-1:0] issue_addr;
    logic [31:0]       pat_seed;
    logic [ADDR_W+1:0] end_addr;

    assign end_addr       = {2'b00, base_addr} + {1'b0, length};
    assign busy           = (state != IDLE);
    assign avm_clken      = 1'b1;
    assign avm_byteenable = 4'hF;
    assign mismatch       = cmp_vld && (avm_readdata != cmp_exp);

    // Next state and the bus access to present in the next cycle
    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        bad_range  = 1'b0;
        issue      = 1'b0;
        issue_wr   = 1'b0;
        issue_addr = addr_q;
        pat_seed   = seed_q;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (length == '0) begin
                        state_n = FIN;
                    end else if (end_addr > DEPTH_W) begin
                        state_n   = FIN;
                        bad_range = 1'b1;
                    end else begin
                        state_n    = WRITE;
                        issue      = 1'b1;
                        issue_wr   = 1'b1;
                        issue_addr = base_addr;
                        pat_seed   = seed;    // seed_q not loaded yet
                    end
                end
            end
            WRITE: begin
                issue = 1'b1;
                if (rem_q == ONE) begin
                    state_n    = READ;
                    issue_addr = base_q;      // first read follows last write
                end else begin
                    issue_wr   = 1'b1;
                    issue_addr = addr_q + 1'b1;
                end
            end
            READ: begin
                if (rem_q == ONE) begin
                    state_n = DRAIN;
                end else begin
                    issue      = 1'b1;
                    issue_addr = addr_q + 1'b1;
                end
            end
            DRAIN:   state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            addr_q         <= '0;
            base_q         <= '0;
            len_q          <= '0;
            rem_q          <= '0;
            seed_q         <= '0;
            cmp_vld        <= 1'b0;
            cmp_addr       <= '0;
            cmp_exp        <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            range_err      <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
        end else begin
            state <= state_n;
            done  <= (state == FIN);
            if (state == FIN)
                pass <= (err_count == 16'd0) && !range_err;

            if (accept) begin
                base_q         <= base_addr;
                len_q          <= length;
                rem_q          <= length;
                seed_q         <= seed;
                err_count      <= '0;
                first_err_addr <= '0;
                pass           <= 1'b0;
                range_err      <= bad_range;
            end else begin
                if (state == WRITE)
                    rem_q <= (rem_q == ONE) ? len_q : rem_q - 1'b1;
                else if (state == READ)
                    rem_q <= rem_q - 1'b1;
                if (mismatch) begin
                    if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                    if (err_count == 16'd0)
                        first_err_addr <= cmp_addr;
                end
            end

            // Address/data registers only move on an access, so they hold
            // their last value while the bus is idle.
            avm_chipselect <= issue;
            avm_write      <= issue_wr;
            if (issue) begin
                addr_q      <= issue_addr;
                avm_address <= issue_addr;
            end
            if (issue_wr)
                avm_writedata <= pat_seed + {{(32-ADDR_W){1'b0}}, issue_addr};

            cmp_vld  <= avm_chipselect && !avm_write;
            cmp_addr <= avm_address;
            cmp_exp  <= seed_q + {{(32-ADDR_W){1'b0}}, avm_address};
        end
    end

endmodule

// File: tb/tb_embedded_system_mem_tester.sv
module tb_embedded_system_mem_tester;

    localparam int ADDR_W = 15;
    localparam int DEPTH  = 25000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic [31:0]       seed = '0;
    logic              busy, done, pass, range_err;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_chipselect, avm_write, avm_clken;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata = '0;

    embedded_system_mem_tester #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .range_err(range_err), .err_count(err_count),
        .first_err_addr(first_err_addr), .avm_address(avm_address),
        .avm_byteenable(avm_byteenable), .avm_chipselect(avm_chipselect),
        .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_clken(avm_clken), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    // Memory model: 1-cycle read latency, optional corruption of words 2 and 3
    logic [31:0] mem [0:DEPTH-1];
    logic        corrupt = 1'b0;
    int          nwr = 0, nrd = 0;
    logic [31:0] wa [0:15];
    logic [31:0] wd [0:15];

    always @(posedge clk) begin
        if (avm_chipselect && avm_write)
            mem[avm_address] <= avm_writedata;
        if (avm_chipselect && !avm_write)
            avm_readdata <= mem[avm_address] ^
                ((corrupt && (avm_address == 2 || avm_address == 3)) ? 32'd1 : 32'd0);
    end

    always @(posedge clk) begin
        if (avm_chipselect) begin
            if (avm_write) begin
                if (nwr < 16) begin
                    wa[nwr] = 32'(avm_address);
                    wd[nwr] = avm_writedata;
                end
                nwr = nwr + 1;
            end else begin
                nrd = nrd + 1;
            end
        end
    end

    int vecs = 0, errs = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one test, optionally pulse start again at edge 'poke' while busy,
    // and return start-to-done latency (start cycle counted as cycle 0).
    task automatic run(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l,
                       input logic [31:0] s, input int poke, output int lat);
        int n;
        nwr = 0;
        nrd = 0;
        base_addr = b;
        length    = l;
        seed      = s;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 300) begin
            if (poke > 0 && n == poke) begin
                start     = 1'b1;
                base_addr = '0;
                length    = 1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
        lat = n + 1;
    endtask

    task automatic after_done();
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        int lat, k, snap, dcnt;

        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_range_err", range_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_err", first_err_addr, 0);
        chk("rst_cs", avm_chipselect, 0);
        chk("rst_wr", avm_write, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_wdata", avm_writedata, 0);
        chk("rst_be", avm_byteenable, 4'hF);
        chk("rst_clken", avm_clken, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        // ---- base 0, length 4, seed 0x1000, ideal memory
        run(0, 4, 32'h1000, 0, lat);
        chk("t1_latency", lat, 11);
        chk("t1_pass", pass, 1);
        chk("t1_err_count", err_count, 0);
        chk("t1_nwr", nwr, 4);
        chk("t1_nrd", nrd, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_waddr", wa[i], i);
            chk("t1_wdata", wd[i], 32'h1000 + i);
        end
        after_done();

        // ---- words 2 and 3 come back with bit 0 flipped
        corrupt = 1'b1;
        run(0, 4, 32'h1000, 0, lat);
        corrupt = 1'b0;
        chk("t2_latency", lat, 11);
        chk("t2_err_count", err_count, 2);
        chk("t2_first_err", first_err_addr, 2);
        chk("t2_pass", pass, 0);
        after_done();

        // ---- last legal word
        run(24999, 1, 32'h55, 0, lat);
        chk("t3_latency", lat, 5);
        chk("t3_pass", pass, 1);
        chk("t3_range_err", range_err, 0);
        chk("t3_nwr", nwr, 1);
        chk("t3_nrd", nrd, 1);
        chk("t3_waddr", wa[0], 24999);
        chk("t3_wdata", wd[0], 32'h55 + 24999);
        after_done();

        // ---- one word past the end
        run(24999, 2, 32'h55, 0, lat);
        chk("t4_latency", lat, 2);
        chk("t4_range_err", range_err, 1);
        chk("t4_pass", pass, 0);
        chk("t4_no_bus", nwr + nrd, 0);
        chk("t4_addr_held", avm_address, 24999);
        after_done();

        // ---- zero length
        run(100, 0, 32'h1, 0, lat);
        chk("t5_latency", lat, 2);
        chk("t5_pass", pass, 1);
        chk("t5_range_err_clr", range_err, 0);
        chk("t5_no_bus", nwr + nrd, 0);
        after_done();

        // ---- start pulsed while busy is ignored
        run(5, 3, 32'd77, 2, lat);
        chk("t6_latency", lat, 9);
        chk("t6_nwr", nwr, 3);
        chk("t6_first_waddr", wa[0], 5);
        chk("t6_pass", pass, 1);
        after_done();

        // ---- reset in the middle of READ
        nwr = 0;
        nrd = 0;
        base_addr = 10;
        length    = 8;
        seed      = 32'h5;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(avm_chipselect && !avm_write) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!(avm_chipselect && !avm_write)) chk("t7_read_timeout", 0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t7_busy", busy, 0);
        chk("t7_cs", avm_chipselect, 0);
        snap = nwr + nrd;
        dcnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("t7_no_done", dcnt, 0);
        chk("t7_no_bus", nwr + nrd, snap);
        run(20, 2, 32'hABCD, 0, lat);
        chk("t7_restart_latency", lat, 7);
        chk("t7_restart_pass", pass, 1);
        after_done();

        // ---- pattern wraps: seed all ones, word 1 holds 0
        run(1, 2, 32'hFFFF_FFFF, 0, lat);
        chk("t8_wdata0", wd[0], 32'h0);
        chk("t8_wdata1", wd[1], 32'h1);
        chk("t8_pass", pass, 1);
        chk("t8_err_count", err_count, 0);
        after_done();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
